// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helpers for ahb_arbiter.
package ahb_arb_pkg;

    localparam int NUM_MST = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_BURST,
        ST_LOCKED
    } arb_state_e;

    // Undefined-length INCR counts as a single beat: it never blocks rearbitration.
    function automatic logic [IDX_W-1:0] burst_len_m1(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MST-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arbiter_pick.sv
// Unused alias package; the picker lives in ahb_rr_pick.sv.
package ahb_arbiter_pick_unused_pkg;
    localparam int UNUSED = 0;
endpackage

// File: rtl/ahb_rr_pick.sv
// 16-way rotating priority encoder: first request at or after start_i wins.
module ahb_rr_pick
    import ahb_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_MST-1:0] gnt_o,
    output logic               vld_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = start_i + IDX_W'(i);
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: burst/lock-aware grant with registered HMASTER/HMASTLOCK.
// AHB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest index wins.
module ahb_arbiter #(
    parameter logic [3:0]  DEF_MST = 4'd0,
    parameter int unsigned NUM_MST = 16
) (
    input  logic               HCLK,
    input  logic               HRST,
    input  logic [NUM_MST-1:0] HBUSREQ_i,
    input  logic [NUM_MST-1:0] HLOCK_i,
    input  logic [1:0]         HTRANS_i,
    input  logic [2:0]         HBURST_i,
    input  logic               HREADY_i,
    output logic [NUM_MST-1:0] HGRANT_o,
    output logic [3:0]         HMASTER_o,
    output logic               HMASTLOCK_o
);
    import ahb_arb_pkg::*;

    localparam logic [NUM_MST-1:0] DEF_GNT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;

    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [3:0]         hmaster_q, hmaster_d;
    logic               hmastlock_q, hmastlock_d;
    logic [3:0]         beats_q, beats_d;
    arb_state_e         state_q, state_d;

    logic               acc, rearb, win_vld;
    logic [3:0]         gnt_idx, start;
    logic [NUM_MST-1:0] win;

    assign gnt_idx = onehot_to_idx(hgrant_q);
    assign acc     = HREADY_i & HTRANS_i[1];

    always_comb begin
        beats_d = beats_q;
        if (acc && HTRANS_i == HTRANS_NONSEQ)
            beats_d = burst_len_m1(HBURST_i);
        else if (acc && HTRANS_i == HTRANS_SEQ && beats_q != 4'd0)
            beats_d = beats_q - 4'd1;
    end

    // Grant may only move between bursts and outside a locked sequence.
    assign rearb = HREADY_i && (beats_d == 4'd0) && !HLOCK_i[gnt_idx];

    ahb_rr_pick u_pick (
        .req_i   (HBUSREQ_i),
        .start_i (start),
        .gnt_o   (win),
        .vld_o   (win_vld)
    );

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0] ptr_q, ptr_d;

    assign start = ptr_q + 4'd1;

    always_comb begin
        ptr_d = ptr_q;
        if (rearb && win_vld) ptr_d = onehot_to_idx(win);
    end

    always_ff @(posedge HCLK) begin
        if (HRST) ptr_q <= DEF_MST;
        else      ptr_q <= ptr_d;
    end
`else
    assign start = 4'd0;
`endif

    always_comb begin
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        state_d     = state_q;
        if (rearb) hgrant_d = win_vld ? win : DEF_GNT;
        if (HREADY_i) begin
            hmaster_d   = gnt_idx;
            hmastlock_d = HLOCK_i[gnt_idx];
            if (HLOCK_i[gnt_idx])   state_d = ST_LOCKED;
            else if (beats_d != 0)  state_d = ST_BURST;
            else if (win_vld)       state_d = ST_OWN;
            else                    state_d = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            hgrant_q    <= DEF_GNT;
            hmaster_q   <= DEF_MST;
            hmastlock_q <= 1'b0;
            beats_q     <= 4'd0;
            state_q     <= ST_IDLE;
        end else begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beats_q     <= beats_d;
            state_q     <= state_d;
        end
    end

    assign HGRANT_o    = hgrant_q;
    assign HMASTER_o   = hmaster_q;
    assign HMASTLOCK_o = hmastlock_q;

endmodule
